// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// counter sizing.
package arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StRun  = ST_RUN,
      StDone = ST_DONE
   } state_e;

   // Bit-slice counter width; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/fs_2x1mux.sv
// Combinational full subtractor (a - b - bin) built only from mux2x1 cells.
module fs_2x1mux (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic b_n;
   logic x;
   logic x_n;

   mux2x1 u_inv_b (.d0(1'b1), .d1(1'b0), .sel(b),   .y(b_n));
   mux2x1 u_xor_ab (.d0(b),   .d1(b_n),  .sel(a),   .y(x));
   mux2x1 u_inv_x (.d0(1'b1), .d1(1'b0), .sel(x),   .y(x_n));
   mux2x1 u_xor_d (.d0(x),    .d1(x_n),  .sel(bin), .y(diff));
   // When a != b the borrow is simply b; when a == b it propagates bin.
   mux2x1 u_bout  (.d0(bin),  .d1(b),    .sel(x),   .y(bout));

endmodule

// File: rtl/mux2x1.sv
// Two-input multiplexer primitive: y = sel ? d1 : d0.
module mux2x1 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/serial_sub_2x1mux.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first,
// with a single mux-based full-subtractor slice and a borrow flop.
module serial_sub_2x1mux
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CW = cnt_w(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             fs_d;
   logic             fs_b;

   fs_2x1mux u_fs (
      .a   (sh_a_q[0]),
      .b   (sh_b_q[0]),
      .bin (br_q),
      .diff(fs_d),
      .bout(fs_b)
   );

   always_comb begin
      state_d = state_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sh_a_d  = a;
               sh_b_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               diff_d  = '0;
               bout_d  = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
            diff_d = {fs_d, diff_q[WIDTH-1:1]};
            br_d   = fs_b;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               bout_d  = fs_b;
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_2x1mux.sv
// Directed self-checking bench for serial_sub_2x1mux at WIDTH=8.
module tb_serial_sub_2x1mux;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;

   int n_checks = 0;
   int n_fail   = 0;

   serial_sub_2x1mux #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .diff (diff),
      .bout (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check_eq({tag, " busy"}, 32'(busy), 32'd0);
      check_eq({tag, " done"}, 32'(done), 32'd0);
      check_eq({tag, " diff"}, 32'(diff), 32'd0);
      check_eq({tag, " bout"}, 32'(bout), 32'd0);
   endtask

   // Pulses start for one edge; returns at the first negedge after capture
   // with the operand inputs scrambled to prove they were latched.
   task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
      @(negedge clk);
      a     = ta;
      b     = tb_v;
      bin   = tbin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      bin   = 1'($urandom);
   endtask

   // Called at negedge number first_cyc after the start edge; returns at
   // the negedge where done is seen (or the cycle budget runs out).
   task automatic wait_result(input string tag, input int first_cyc,
                              input logic [7:0] exp_diff, input logic exp_bout);
      int cyc    = first_cyc;
      int busy_n = 0;
      int both   = 0;
      while (!done && cyc < 30) begin
         if (busy) busy_n++;
         @(negedge clk);
         cyc++;
      end
      if (busy && done) both++;
      check_eq({tag, " latency"}, 32'(cyc), 32'd9);
      check_eq({tag, " busy cycles"}, 32'(busy_n), 32'(9 - first_cyc));
      check_eq({tag, " busy&done"}, 32'(both), 32'd0);
      check_eq({tag, " diff"}, 32'(diff), 32'(exp_diff));
      check_eq({tag, " bout"}, 32'(bout), 32'(exp_bout));
   endtask

   task automatic after_done(input string tag);
      @(negedge clk);
      check_eq({tag, " done width"}, 32'(done), 32'd0);
      check_eq({tag, " busy after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst_n = 1'b1;

      begin
         int act = 0;
         repeat (20) begin
            @(negedge clk);
            if (busy || done) act++;
         end
         check_eq("idle 20 cycles activity", 32'(act), 32'd0);
      end

      launch(8'h5A, 8'h3C, 1'b0);
      wait_result("5A-3C", 1, 8'h1E, 1'b0);
      after_done("5A-3C");

      launch(8'h00, 8'h01, 1'b0);
      wait_result("00-01", 1, 8'hFF, 1'b1);
      after_done("00-01");

      launch(8'h80, 8'h80, 1'b1);
      wait_result("80-80-1", 1, 8'hFF, 1'b1);
      after_done("80-80-1");

      launch(8'hFF, 8'h00, 1'b1);
      wait_result("FF-00-1", 1, 8'hFE, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("hold diff", 32'(diff), 32'hFE);
         check_eq("hold bout", 32'(bout), 32'd0);
      end

      // Start re-pulsed mid-RUN must be ignored.
      launch(8'h5A, 8'h3C, 1'b0);
      @(negedge clk);
      a     = 8'h11;
      b     = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_result("restart ignored", 3, 8'h1E, 1'b0);
      // Start raised in the done cycle and held into the following idle cycle.
      a     = 8'h33;
      b     = 8'h11;
      bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check_eq("b2b done dropped", 32'(done), 32'd0);
      check_eq("b2b not busy yet", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      a     = 8'hA5;
      b     = 8'hC3;
      wait_result("b2b 33-11", 1, 8'h22, 1'b0);
      after_done("b2b 33-11");

      // Reset in the fourth RUN cycle aborts the operation.
      launch(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      check_eq("pre-abort busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int dn = 0;
         repeat (12) begin
            @(negedge clk);
            if (done || busy) dn++;
         end
         check_eq("no done after abort", 32'(dn), 32'd0);
      end

      launch(8'h10, 8'h01, 1'b0);
      wait_result("10-01", 1, 8'h0F, 1'b0);
      after_done("10-01");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
